// File: rtl/mul_ext_unit.sv
// mul_ext_unit: RV32M multiply sequencer around a fixed-latency unsigned 32x32 multiplier core.
// Feeds operand magnitudes to the core, then restores the sign and picks the low or high word.
module mul_ext_unit #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p
);
    typedef enum logic [1:0] {IDLE, WAIT, FIN, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_LAT - 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d, result_q, result_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic              accept, sgn1, sgn2;
    logic [63:0]       q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (flush) state_d = IDLE;
        else
            case (state_q)
                IDLE, DONE: state_d = start ? WAIT : IDLE;
                WAIT:       state_d = (cnt_q == LAST) ? FIN : WAIT;
                default:    state_d = DONE;
            endcase
    end
    // Signedness: rs1 signed unless MULHU, rs2 signed only for MUL/MULH.
    always_comb begin
        accept   = (state_q == IDLE || state_q == DONE) && start && !flush;
        sgn1     = op != 2'b11;
        sgn2     = !op[1];
        cnt_d    = (state_q == WAIT && !flush) ? cnt_q + 1'b1 : '0;
        mul_a_d  = accept ? ((sgn1 && rs1[31]) ? -rs1 : rs1) : mul_a_q;
        mul_b_d  = accept ? ((sgn2 && rs2[31]) ? -rs2 : rs2) : mul_b_q;
        neg_d    = accept ? ((sgn1 & rs1[31]) ^ (sgn2 & rs2[31])) : neg_q;
        op_d     = accept ? op : op_q;
        q        = neg_q ? ~mul_p + 64'd1 : mul_p;
        result_d = (state_q == FIN && !flush) ? ((op_q == 2'b00) ? q[31:0] : q[63:32]) : result_q;
    end
    always_comb begin
        busy   = state_q == WAIT || state_q == FIN;
        done   = state_q == DONE;
        result = result_q;
        mul_a  = mul_a_q;
        mul_b  = mul_b_q;
    end
endmodule

// File: tb/tb_mul_ext_unit.sv
// tb_mul_ext_unit: directed checks of the multiply sequencer against a pipelined multiplier model.
module tb_mul_ext_unit;
    localparam int LAT = 3;
    logic        clk = 1'b0, rstn, start, flush;
    logic [1:0]  op;
    logic [31:0] rs1, rs2, result, mul_a, mul_b;
    logic        busy, done;
    logic [63:0] mul_p;
    logic [63:0] pipe [LAT];
    int          n_pass = 0, n_chk = 0;
    always #5 clk = ~clk;
    mul_ext_unit #(.MUL_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );
    always_ff @(posedge clk) begin
        pipe[0] <= 64'(mul_a) * 64'(mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[LAT-1];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; op = ~o; rs1 = ~a; rs2 = ~b;
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_res"}, 64'(result), 64'(exp));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask
    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0; rs1 = 32'h1234_5678; rs2 = '0; op = 2'b11;
        check("t1_mul_a", 64'(mul_a), 64'd7);
        check("t1_mul_b", 64'(mul_b), 64'd3);
        for (int c = 1; c <= 4; c++) begin
            check("t1_busy", 64'(busy), 64'd1);
            check("t1_done", 64'(done), 64'd0);
            @(negedge clk);
        end
        check("t1_done5", 64'(done), 64'd1);
        check("t1_busy5", 64'(busy), 64'd0);
        check("t1_res", 64'(result), 64'hFFFF_FFEB);
        @(negedge clk);
        check("t1_pulse", 64'(done), 64'd0);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("mulh_zero", 2'b01, 32'h0, 32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hold_a", 64'(mul_a), 64'd0);
        check("idle_hold_b", 64'(mul_b), 64'd1);
        start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        rs1 = 32'd9; rs2 = 32'd9;
        wait_done(n);
        check("b2b1_lat", 64'(n), 64'd5);
        check("b2b1_res", 64'(result), 64'd15);
        rs1 = 32'd2; rs2 = 32'd2;
        @(negedge clk);
        start = 1'b0; rs1 = 32'd9; rs2 = 32'd9;
        wait_done(n);
        check("b2b2_lat", 64'(n), 64'd5);
        check("b2b2_res", 64'(result), 64'd4);
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_done", 64'(done), 64'd0);
        check("fl_res", 64'(result), 64'd4);
        run_op("fl_next", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("fin_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("fin_done", 64'(done), 64'd0);
        check("fin_res", 64'(result), 64'hFFFF_FFFE);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("fl_beats_start", 64'(busy), 64'd0);
        start = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_done", 64'(done), 64'd0);
        check("ar_res", 64'(result), 64'd0);
        check("ar_mul_a", 64'(mul_a), 64'd0);
        check("ar_mul_b", 64'(mul_b), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("ar_no_done", 64'(done), 64'd0);
        run_op("ar_mul", 2'b00, 32'd6, 32'd7, 32'd42);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mul_ext_unit.md
Name: mul_ext_unit

Overview:
- RV32M multiply sequencer sitting between the EX stage and the pipelined unsigned 32x32 multiplier core.
- Converts signed operands to magnitudes and drives the multiplier.
- Counts the fixed core latency, then re-applies sign and selects the low or high word.
- Presents a registered 32-bit result with a busy/done handshake that the pipeline control uses for stalling.

Parameters:
- MUL_LAT, 3, cycles from mul_a/mul_b registered to mul_p valid in the multiplier core (legal range 1..15).
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1  input  32  operand 1
- rs2  input  32  operand 2
- flush  input  1  synchronous abort from pipeline control
- busy  output  1  operation in flight; EX stage stalls while high
- done  output  1  one-cycle pulse; result valid
- result  output  32  registered result; held until the next done
- mul_a  output  32  registered magnitude of rs1 to the multiplier
- mul_b  output  32  registered magnitude of rs2 to the multiplier
- mul_p  input  64  unsigned product from the multiplier, MUL_LAT cycles after mul_a/mul_b

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, counter 0, busy 0, done 0, result 0, mul_a 0, mul_b 0, sign and op latches 0. A reset mid-operation discards the operation; no done is produced.
- Operand signedness:
  - rs1 is signed for MUL, MULH and MULHSU.
  - rs2 is signed for MUL and MULH.
  - MULHU treats both operands as unsigned.
- Magnitude: if an operand is signed and bit31=1, its magnitude is the two's-complement negation, else the raw value. 0x80000000 maps to 0x80000000 as an unsigned 32-bit value; no overflow.
- neg = (signed1 & rs1[31]) ^ (signed2 & rs2[31]), latched together with op at acceptance.
- States:
  - IDLE: busy 0. On start & !flush: latch mul_a, mul_b, neg and op; counter 0; go to WAIT.
  - WAIT: busy 1. Counter increments each cycle. When counter == MUL_LAT-1, go to FIN.
  - FIN: busy 1. Sample mul_p into P. result = op==MUL ? Q[31:0] : Q[63:32], where Q = neg ? (~P + 1) as 64-bit : P. Set done=1 and go to DONE.
  - DONE: busy 0, done 1 for this cycle only. start is accepted exactly as in IDLE (back-to-back). Without start, go to IDLE.
- Timing: start sampled at edge E0 means mul_a valid in cycle 1 and mul_p valid in cycle 1+MUL_LAT. With MUL_LAT=3 this gives:
  - busy high in cycles 1..MUL_LAT+1.
  - done and result visible in cycle MUL_LAT+2, i.e. 5 cycles after the start edge.
- Throughput: one operation per MUL_LAT+2 cycles (accept in DONE).
- start while busy is ignored; no queuing.
- Operands are sampled only at acceptance; rs1, rs2 and op may change freely afterwards.
- flush (any state): next state IDLE, counter 0, busy 0, done 0. result keeps its old value. flush beats start in the same cycle. flush in FIN suppresses the done/result update.
- done and busy are never both high.
- mul_a and mul_b hold their last accepted values while IDLE.
- Zero product with neg=1 yields 0; the negation wraps correctly.

Test Plan:
- MUL_LAT=3, MUL rs1=7 rs2=0xFFFFFFFD -> mul_a=7, mul_b=3; busy cycles 1-4; done in cycle 5; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> product 0xFFFFFFFF00000001, result=0xFFFFFFFF. MULH 0 x 0xFFFFFFFF -> result=0.
- Back-to-back: start held high with MUL 3x5 then MUL 2x2 presented in the done cycle -> results 15 then 4; done pulses 5 cycles apart; start during busy ignored.
- flush asserted in cycle 2 of MULHU -> busy low next cycle, no done, result unchanged. A fresh start in the following cycle completes normally.
- rstn pulled low in WAIT -> busy, done, result, mul_a and mul_b read 0 immediately. After release, a MUL 6x7 returns 42 with standard latency.
- Bench models the multiplier as a MUL_LAT-deep register pipeline of mul_a*mul_b.
